// File: rtl/edge_pkg.sv
// Shared types for the edge debouncer: the per-channel edge mode and the
// decode that decides whether an accepted transition should raise a tick.
package edge_pkg;

   typedef enum logic [1:0] {
      EDGE_OFF  = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_mode_e;

   function automatic logic tick_enabled(input edge_mode_e mode, input logic new_level);
      logic en_s;
      case (mode)
         EDGE_OFF:  en_s = 1'b0;
         EDGE_RISE: en_s = new_level;
         EDGE_FALL: en_s = ~new_level;
         EDGE_BOTH: en_s = 1'b1;
         default:   en_s = 1'b0;
      endcase
      return en_s;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser chain, stability counter and the
// registered level/tick pair for a single raw signal.
module debounce_channel
   import edge_pkg::*;
#(
   parameter int DELAY       = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sig,
   input  edge_mode_e mode,
   output logic       level,
   output logic       tick
);

   localparam int            CW       = $clog2(DELAY + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_s;
   logic [CW-1:0]          cnt_r;
   logic                   level_r;
   logic                   tick_r;

   // Metastability guard: shift the raw input through the flop chain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], sig};
      end
   end

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Accept a new level only after DELAY consecutive differing samples;
   // any sample matching the current level restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= {CW{1'b0}};
         level_r <= 1'b0;
         tick_r  <= 1'b0;
      end else begin
         tick_r <= 1'b0;
         if (sync_s == level_r) begin
            cnt_r <= {CW{1'b0}};
         end else if (cnt_r == CNT_LAST) begin
            level_r <= sync_s;
            cnt_r   <= {CW{1'b0}};
            tick_r  <= tick_enabled(mode, sync_s);
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   assign level = level_r;
   assign tick  = tick_r;

endmodule

// File: rtl/multi_edge_debouncer.sv
// N independent debounced edge detectors with per-channel edge-mode
// selection and a combined tick flag.
module multi_edge_debouncer
   import edge_pkg::*;
#(
   parameter int N           = 4,
   parameter int DELAY       = 20,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      sig,
   input  logic [N-1:0][1:0] mode,
   output logic [N-1:0]      level,
   output logic [N-1:0]      tick,
   output logic              any_tick
);

   for (genvar i = 0; i < N; i++) begin : g_ch
      debounce_channel #(
         .DELAY       (DELAY),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .sig   (sig[i]),
         .mode  (edge_mode_e'(mode[i])),
         .level (level[i]),
         .tick  (tick[i])
      );
   end

   assign any_tick = |tick;

endmodule

// File: tb/tb_multi_edge_debouncer.sv
// Scoreboard bench: stimulus pushes expected tick events (edge index, tick
// vector, level vector); a negedge monitor pops and compares each tick.
module tb_multi_edge_debouncer;

   typedef struct {
      int         cyc;
      logic [3:0] tick;
      logic [3:0] level;
   } exp_t;

   logic            clk;
   logic            rst;
   logic [3:0]      sig;
   logic [3:0][1:0] mode;
   logic [3:0]      level;
   logic [3:0]      tick;
   logic            any_tick;

   int   cyc;
   int   checks;
   int   failures;
   exp_t sb[$];

   multi_edge_debouncer #(.N(4), .DELAY(20), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .sig      (sig),
      .mode     (mode),
      .level    (level),
      .tick     (tick),
      .any_tick (any_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count rising edges so expectations can name the edge a tick lands on.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic push(input int c, input logic [3:0] t, input logic [3:0] l);
      exp_t e;
      e.cyc   = c;
      e.tick  = t;
      e.level = l;
      sb.push_back(e);
   endtask

   // Monitor: every cycle showing a tick must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && (tick !== 4'b0000 || any_tick !== 1'b0)) begin
         if (sb.size() == 0) begin
            chk("unexpected_tick", {28'd0, tick}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("tick_cycle", cyc, e.cyc);
            chk("tick_vec", {28'd0, tick}, {28'd0, e.tick});
            chk("tick_level", {28'd0, level}, {28'd0, e.level});
            chk("any_tick", {31'd0, any_tick}, 32'd1);
         end
      end
   end

   initial begin
      int c;
      cyc  = 0;
      checks = 0;
      failures = 0;
      rst  = 1'b1;
      sig  = 4'b0000;
      mode = {4{2'b11}};

      // Reset state, then 30 quiet cycles after release.
      @(negedge clk);
      chk("reset_level", {28'd0, level}, 32'd0);
      chk("reset_tick", {31'd0, any_tick}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         chk("idle_outputs", {27'd0, any_tick, level}, 32'd0);
      end

      // ch0 RISE: tick on rise at e0+21, no tick on fall.
      mode[0] = 2'b01;
      @(negedge clk);
      c = cyc;
      sig[0] = 1'b1;
      push(c + 22, 4'b0001, 4'b0001);
      wait_until(c + 21);
      chk("ch0_level_before_rise", {31'd0, level[0]}, 32'd0);
      wait_until(c + 30);
      c = cyc;
      sig[0] = 1'b0;
      wait_until(c + 21);
      chk("ch0_level_before_fall", {31'd0, level[0]}, 32'd1);
      wait_until(c + 22);
      chk("ch0_level_after_fall", {31'd0, level[0]}, 32'd0);
      wait_cycles(8);

      // ch1 BOTH: bounced rise; final stable sample lands on edge c+9.
      @(negedge clk);
      c = cyc;
      push(c + 30, 4'b0010, 4'b0010);
      #3  sig[1] = 1'b1;
      #17 sig[1] = 1'b0;
      #3  sig[1] = 1'b1;
      #8  sig[1] = 1'b0;
      #7  sig[1] = 1'b1;
      #8  sig[1] = 1'b0;
      #11 sig[1] = 1'b1;
      #13 sig[1] = 1'b0;
      #7  sig[1] = 1'b1;
      wait_until(c + 29);
      chk("ch1_level_before", {31'd0, level[1]}, 32'd0);
      wait_until(c + 40);

      // ch2 BOTH, ch3 FALL: 300 ns pulse on both.
      mode[3] = 2'b10;
      @(negedge clk);
      c = cyc;
      sig[3:2] = 2'b11;
      push(c + 22, 4'b0100, 4'b1110);
      wait_until(c + 30);
      c = cyc;
      sig[3:2] = 2'b00;
      push(c + 22, 4'b1100, 4'b0010);
      wait_until(c + 30);

      // All BOTH, simultaneous toggle, then the same with all OFF.
      mode = {4{2'b11}};
      @(negedge clk);
      c = cyc;
      sig = 4'b1101;
      push(c + 22, 4'b1111, 4'b1101);
      wait_until(c + 22);
      chk("all_any_tick_on", {31'd0, any_tick}, 32'd1);
      wait_until(c + 23);
      chk("all_any_tick_off", {31'd0, any_tick}, 32'd0);
      wait_until(c + 30);
      mode = {4{2'b00}};
      c = cyc;
      sig = 4'b0010;
      wait_until(c + 22);
      chk("off_level", {28'd0, level}, 32'h2);
      chk("off_tick", {28'd0, tick}, 32'd0);
      wait_cycles(8);
      sig = 4'b0000;
      wait_cycles(30);
      chk("quiet_level", {28'd0, level}, 32'd0);

      // Reset mid-count on ch0 discards progress; full latency afterwards.
      mode = {4{2'b11}};
      @(negedge clk);
      c = cyc;
      sig[0] = 1'b1;
      push(c + 35, 4'b0001, 4'b0001);
      wait_until(c + 12);
      rst = 1'b1;
      #1;
      chk("midreset_outputs", {27'd0, any_tick, level}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_until(c + 34);
      chk("post_reset_level_before", {31'd0, level[0]}, 32'd0);
      wait_until(c + 40);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/multi_edge_debouncer.md
# multi_edge_debouncer

N-channel debounced edge detector with per-channel edge-mode selection. Each raw asynchronous input is synchronised, must hold a new level for DELAY consecutive clocks before it is accepted, and then produces a debounced level plus a one-cycle tick when the accepted edge matches that channel's mode. It sits between raw button, switch or external-strobe pins and the control FSMs that consume single-cycle events.

## Interface
- N, 4: number of independent channels (≥1)
- DELAY, 20: consecutive stable clocks required to accept a change (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- sig  in  N  raw, asynchronous inputs
- mode  in  N×2 (packed [N-1:0][1:0])  per-channel edge_mode_e: 00 OFF, 01 RISE, 10 FALL, 11 BOTH; synchronous to clk
- level  out  N  debounced level
- tick  out  N  one-cycle pulse on accepted edge matching mode
- any_tick  out  1  OR of tick

## Operation
- Per channel: SYNC_STAGES flop chain → sync; counter cnt of width $clog2(DELAY+1); registered level and tick.
- At each edge, if sync == level, then cnt ← 0.
- At each edge, if sync != level and cnt < DELAY-1, then cnt ← cnt+1.
- At each edge, if sync != level and cnt == DELAY-1, then level ← sync and cnt ← 0. tick ← 1 iff the new level is 1 and mode ∈ {RISE, BOTH}, or the new level is 0 and mode ∈ {FALL, BOTH}.
- tick is 0 on every other cycle, so it is never high for two consecutive cycles.
- A glitch, meaning sync returning to level before the DELAY-th differing edge, clears cnt. No level change and no tick result.
- mode gates tick only. It never affects cnt or level. A mode change takes effect on the next evaluated edge. OFF still tracks level.
- Channels are fully independent. Simultaneous accepted edges on several channels produce ticks in the same cycle.
- any_tick is combinational OR of registered tick bits.

## Timing
- Reset values: sync chain 0, cnt 0, level 0, tick 0, any_tick 0.
- Reset asserted mid-count discards progress immediately.
- After reset release, an input held high is treated as a rising edge and accepted after full latency.
- Latency: let e0 be the first clk edge sampling the new sig value. level and tick update at edge e0 + SYNC_STAGES + DELAY − 1.
- With the defaults this is edge e0+21.
- Minimum accepted pulse width: DELAY clocks at sync, i.e. 200 ns with T = 10 ns.
- tick is high for exactly one clock, coincident with the first cycle of the new level.

## Structure
- Package edge_pkg holds typedef enum logic [1:0] edge_mode_e {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
- Sub-module debounce_channel contains one synchroniser, counter and level/tick logic, parametrised by DELAY and SYNC_STAGES. Top instantiates it N times via generate and ORs the ticks.

## Test plan
Bench parameters: N=4, DELAY=20, SYNC_STAGES=2, T=10 ns.
- Reset: rst=1 for 1 cycle, sig=0, all modes BOTH → level=0, tick=0, any_tick=0 throughout and for 30 cycles after release.
- ch0 mode RISE, sig[0] 0→1 held 300 ns → tick[0]=1 for exactly one cycle at edge e0+21 and level[0]=1 from that edge. ticks[3:1]=0; falling edge 300 ns later → level[0]=0, no tick.
- ch1 mode BOTH, bounce sig[1] high/low with segments 17, 3, 8, 7, 8, 11, 13, 7, 3 ns, then hold high 300 ns → no tick during bounce, single tick[1] 21 edges after final stable sampling edge.
- ch2 BOTH and ch3 FALL, each pulsed high 300 ns then low → ch2: two ticks (rise, fall), ch3: one tick on fall. level tracks on both.
- All channels mode BOTH, all sig toggled in the same cycle → tick=4'b1111 in one cycle, any_tick high exactly one cycle. Then mode=OFF and toggle again → level changes, tick stays 0.
- sig[0] held high, rst pulsed at cnt=10 → level[0]=0 and cnt cleared. After release, tick[0] occurs a full 21 edges after the first post-reset sampling edge.
